// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_P0   = 2'd1,
        ARB_P1   = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic     i_req0,
    input  logic     i_req1,
    input  port_id_t i_last_grant,
    output logic     o_grant_valid,
    output port_id_t o_grant_id
);

    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_grant_id = ~i_last_grant;
        end else if (i_req1) begin
            o_grant_id = PORT1;
        end else begin
            o_grant_id = PORT0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (port 0)
// and a second bus master (port 1); a grant is held for one full transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_resp,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_resp,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    port_id_t   r_last_grant;
    port_id_t   w_next_last_grant;
    logic       w_req0;
    logic       w_req1;
    logic       w_grant_valid;
    port_id_t   w_grant_id;

    assign w_req0 = p0_read | p0_write;
    assign w_req1 = p1_read | p1_write;

    rr_pick2 u_pick (
        .i_req0        (w_req0),
        .i_req1        (w_req1),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Port 1 counts as last granted out of reset so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= PORT1;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_address       = '0;
        mem_wdata         = '0;
        p0_resp           = 1'b0;
        p1_resp           = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // mem_resp is deliberately ignored here.
                if (w_grant_valid) begin
                    w_next_state      = (w_grant_id == PORT1) ? ARB_P1 : ARB_P0;
                    w_next_last_grant = w_grant_id;
                end
            end
            ARB_P0: begin
                mem_read    = p0_read;
                mem_write   = p0_write;
                mem_address = p0_address;
                mem_wdata   = p0_wdata;
                if (mem_resp) begin
                    p0_resp      = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_P1: begin
                mem_read    = p1_read;
                mem_write   = p1_write;
                mem_address = p1_address;
                mem_wdata   = p1_wdata;
                if (mem_resp) begin
                    p1_resp      = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requesters, a 2-cycle memory model and a
// scoreboard monitor that checks every resp against the expected service order.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_read, p0_write, p1_read, p1_write;
    logic [7:0] p0_address, p0_wdata, p1_address, p1_wdata;
    logic       p0_resp, p1_resp;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_wdata;
    logic       mem_resp;
    logic [7:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       port;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_resp = 1'b0;

    logic [7:0] mem_array [0:255];
    logic [1:0] m_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .p0_read     (p0_read),
        .p0_write    (p0_write),
        .p0_address  (p0_address),
        .p0_wdata    (p0_wdata),
        .p0_resp     (p0_resp),
        .p0_rdata    (p0_rdata),
        .p1_read     (p1_read),
        .p1_write    (p1_write),
        .p1_address  (p1_address),
        .p1_wdata    (p1_wdata),
        .p1_resp     (p1_resp),
        .p1_rdata    (p1_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    // Memory: contents addr ^ 8'h5A after reset; resp two edges after the strobe is seen.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_resp <= 1'b0;
            m_cnt    <= 2'd0;
            for (int i = 0; i < 256; i++) mem_array[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_resp) begin
            mem_resp <= 1'b0;
            m_cnt    <= 2'd0;
        end else if (mem_read || mem_write) begin
            if (m_cnt == 2'd1) begin
                mem_resp <= 1'b1;
                if (mem_read)  mem_rdata <= mem_array[mem_address];
                if (mem_write) mem_array[mem_address] <= mem_wdata;
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic port, input logic wr, input logic [7:0] addr,
                            input logic [7:0] rdata);
        exp_t e;
        e.port = port; e.wr = wr; e.addr = addr; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int port, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata);
        if (port == 0) begin
            p0_read = ~wr; p0_write = wr; p0_address = addr; p0_wdata = wdata;
        end else begin
            p1_read = ~wr; p1_write = wr; p1_address = addr; p1_wdata = wdata;
        end
    endtask

    task automatic release_port(input int port);
        if (port == 0) begin
            p0_read = 1'b0; p0_write = 1'b0;
        end else begin
            p1_read = 1'b0; p1_write = 1'b0;
        end
    endtask

    // Waits for the port's resp, then drops the strobes just after the resp edge.
    task automatic wait_resp(input int port);
        int  n   = 0;
        bit  got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = (port == 0) ? p0_resp : p1_resp;
            n++;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_timeout: port %0d got no resp within 50 cycles", port);
        end
        @(posedge clk);
        #1;
        release_port(port);
    endtask

    task automatic txn(input int port, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata);
        @(posedge clk);
        #1;
        drive(port, wr, addr, wdata);
        wait_resp(port);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (prev_resp) check("idle_gap_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        if (p0_resp && p1_resp) begin
            check("resp_overlap", {30'd0, p0_resp, p1_resp}, 32'd0);
        end else if (p0_resp || p1_resp) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {30'd0, p0_resp, p1_resp}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_port", {31'd0, p1_resp}, {31'd0, mon_e.port});
                check("resp_address", {24'd0, mem_address}, {24'd0, mon_e.addr});
                if (!mon_e.wr) begin
                    check("resp_rdata", {24'd0, p1_resp ? p1_rdata : p0_rdata},
                          {24'd0, mon_e.rdata});
                end
            end
        end
        prev_resp <= p0_resp | p1_resp;
    end

    initial begin
        rst = 1'b1;
        p0_read = 0; p0_write = 0; p0_address = 0; p0_wdata = 0;
        p1_read = 0; p1_write = 0; p1_address = 0; p1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr_wdata", {16'd0, mem_address, mem_wdata}, 32'd0);
        check("rst_resps", {30'd0, p0_resp, p1_resp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, port 0.
        push_exp(1'b0, 1'b0, 8'h10, 8'h4A);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h10, 8'h00);
        check("p0_rd_before_grant", {31'd0, mem_read}, 32'd0);
        @(posedge clk);
        #1;
        check("p0_rd_strobe", {30'd0, mem_read, mem_write}, 32'd2);
        check("p0_rd_addr", {24'd0, mem_address}, 32'h10);
        wait_resp(0);

        // Single write, port 1, then read back through port 0.
        push_exp(1'b1, 1'b1, 8'hF0, 8'h00);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 8'hF0, 8'hA5);
        @(posedge clk);
        #1;
        check("p1_wr_strobe", {30'd0, mem_read, mem_write}, 32'd1);
        check("p1_wr_addr_data", {16'd0, mem_address, mem_wdata}, 32'hF0A5);
        wait_resp(1);
        push_exp(1'b0, 1'b0, 8'hF0, 8'hA5);
        txn(0, 1'b0, 8'hF0, 8'h00);

        // Simultaneous requests straight out of reset: port 0 first.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_exp(1'b0, 1'b0, 8'h01, 8'h5B);
        push_exp(1'b1, 1'b0, 8'h02, 8'h58);
        fork
            txn(0, 1'b0, 8'h01, 8'h00);
            txn(1, 1'b0, 8'h02, 8'h00);
        join

        // Continuous contention: strict alternation starting with port 0.
        push_exp(1'b0, 1'b0, 8'h20, 8'h7A);
        push_exp(1'b1, 1'b0, 8'h30, 8'h6A);
        push_exp(1'b0, 1'b0, 8'h21, 8'h7B);
        push_exp(1'b1, 1'b0, 8'h31, 8'h6B);
        push_exp(1'b0, 1'b0, 8'h22, 8'h78);
        push_exp(1'b1, 1'b0, 8'h32, 8'h68);
        fork
            begin
                for (int i = 0; i < 3; i++) txn(0, 1'b0, 8'h20 + 8'(i), 8'h00);
            end
            begin
                for (int j = 0; j < 3; j++) txn(1, 1'b0, 8'h30 + 8'(j), 8'h00);
            end
        join

        // Reset in the middle of a port 1 transaction.
        @(posedge clk);
        #1;
        drive(1, 1'b0, 8'h40, 8'h00);
        @(posedge clk);
        #1;
        check("p1_abort_granted", {23'd0, mem_read, mem_address}, 32'h140);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("midrst_addr", {24'd0, mem_address}, 32'd0);
        check("midrst_resps", {30'd0, p0_resp, p1_resp}, 32'd0);
        check("midrst_rdata_follow", {24'd0, p0_rdata}, {24'd0, mem_rdata});
        repeat (2) @(posedge clk);
        #1;
        release_port(1);
        @(negedge clk);
        rst = 1'b0;
        push_exp(1'b1, 1'b0, 8'h41, 8'h1B);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 8'h41, 8'h00);
        @(posedge clk);
        #1;
        check("p1_reissue_granted", {23'd0, mem_read, mem_address}, 32'h141);
        wait_resp(1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single 8-bit memory port between two requesters: the tiny8v1 core on port 0 and a second bus master (data/DMA engine) on port 1. It sits between the requesters and `memory` and presents each requester the same read/write/resp handshake the memory itself uses. It holds the grant for one full transaction, from the cycle it is granted until the cycle `mem_resp` is seen.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: address width on all ports.
- `DATA_WIDTH`, default 8: data width on all ports.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_read`, `p0_write`  in  1 each  port 0 (core) request strobes.
- `p0_address`  in  ADDR_WIDTH  port 0 address.
- `p0_wdata`  in  DATA_WIDTH  port 0 write data.
- `p0_resp`  out  1  port 0 transaction complete.
- `p0_rdata`  out  DATA_WIDTH  port 0 read data.
- `p1_read`, `p1_write`, `p1_address`, `p1_wdata`, `p1_resp`, `p1_rdata`: same as the port 0 signals, for port 1.
- `mem_read`, `mem_write`  out  1 each  strobes to memory.
- `mem_address`  out  ADDR_WIDTH  address to memory.
- `mem_wdata`  out  DATA_WIDTH  write data to memory.
- `mem_resp`  in  1  memory completion.
- `mem_rdata`  in  DATA_WIDTH  memory read data.

## Operation
- A port is requesting when its `read | write` is high.
- A requester holds read, write, address and wdata stable until the cycle its resp is high, and drops the strobes on the following cycle.
- FSM states are `ARB_IDLE`, `ARB_P0` and `ARB_P1`.
- `ARB_IDLE`:
  - Memory strobes are 0, and `mem_address` and `mem_wdata` are 0.
  - If exactly one port is requesting, go to that port's state.
  - If both ports are requesting, grant the port that is not `last_grant`, then update `last_grant` to the granted port.
  - A single grant also updates `last_grant`.
- `ARB_Px`:
  - Port x's read, write, address and wdata drive the memory port combinationally.
  - When `mem_resp` is 1, drive `px_resp` = 1 in the same cycle (combinational) and go to `ARB_IDLE`.
  - The other port's resp stays 0.
- `mem_resp` in `ARB_IDLE` is ignored and is never forwarded.
- `mem_rdata` is broadcast to both `p0_rdata` and `p1_rdata` at all times. It is valid only when the port's resp is high.
- If a port asserts read and write together, both are forwarded unchanged. This is illegal usage and is not checked.

## Timing
- Reset (asynchronous, immediate):
  - State goes to `ARB_IDLE`, and `last_grant` is set to port 1, so port 0 wins the first tie.
  - All `mem_*` outputs and both resps are 0.
  - `px_rdata` continues to follow `mem_rdata`.
- Latency:
  - A request seen in `ARB_IDLE` at edge N shows its memory strobe after edge N+1.
  - A port's resp coincides with `mem_resp`.
  - There is one mandatory `ARB_IDLE` cycle between back-to-back transactions, so the minimum transaction is memory latency + 1 cycle.
- Reset asserted mid-transaction: strobes drop immediately and the outstanding transaction is abandoned. No resp is delivered. The requester re-issues after reset.
- A request arriving while the other port is granted waits. Under continuous contention, grants alternate strictly, so each port waits at most one transaction.
- A requester that drops its strobes before resp is illegal. The arbiter still waits for `mem_resp`.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (`ARB_IDLE`, `ARB_P0`, `ARB_P1`);
  - the `port_id_t` type (1 bit) used for `last_grant`;
  - default width constants of 8.
- One sub-module is natural: `rr_pick2`, combinational. Inputs are the two request bits and `last_grant`; outputs are `grant_valid` and `grant_id`.
- The FSM, the `last_grant` register and the output muxing live in `mem_arbiter`.

## Test plan
- Reset then idle: `rst`=1 mid-sim → all `mem_*` strobes, `mem_address` and resps are 0 immediately; `p0_rdata` equals `mem_rdata`.
- Single read, port 0, memory with 2-cycle response: `p0_read`=1, `p0_address`=8'h10 →
  - `mem_read`=1 and `mem_address`=8'h10 one cycle later;
  - `p0_resp`=1 with `p0_rdata` = memory[8'h10] on the `mem_resp` cycle;
  - `p1_resp` stays 0.
- Single write, port 1: `p1_write`=1, `p1_address`=8'hF0, `p1_wdata`=8'hA5 → `mem_write`=1 with 8'hF0/8'hA5; after `p1_resp`, a port 0 read of 8'hF0 returns 8'hA5.
- Simultaneous requests out of reset: both read, addresses 8'h01 and 8'h02 → port 0 is served first, then port 1 after one `ARB_IDLE` cycle; the resps never overlap.
- Continuous contention over 6 transactions → grant order is 0, 1, 0, 1, 0, 1.
- Reset during `ARB_P1` before `mem_resp` → strobes drop asynchronously and no `p1_resp` is seen; after release, port 1 re-issues and is granted on its first request if port 0 is idle.
